// File: rtl/filtre_serilestirici.sv
// filtre_serilestirici: legality check of filtered pixel words, FIFO buffering,
// and framed MSB-first serial transmission (start, 5 data, even parity, stop).
module filtre_serilestirici #(
  parameter int FIFO_DERINLIK = 4,
  parameter int BIT_BOLEN     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [4:0]                       filtrelenmis_resim,
  input  logic                             giris_gecerli,
  output logic                             giris_hazir,
  output logic                             seri_cikis,
  output logic                             mesgul,
  output logic [$clog2(FIFO_DERINLIK):0]   doluluk,
  output logic [7:0]                       piksel_sayaci,
  output logic [7:0]                       gecersiz_sayaci
);

  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int TW = (BIT_BOLEN > 1) ? $clog2(BIT_BOLEN) : 1;
  localparam logic [AW:0]   DOLU = (AW+1)'(FIFO_DERINLIK);
  localparam logic [TW-1:0] SON  = TW'(BIT_BOLEN - 1);

  typedef enum logic [2:0] {BOS, BASLA, VERI, ESLIK, DUR} durum_t;

  durum_t          durum, durum_n;
  logic [TW-1:0]   zaman, zaman_n;
  logic [2:0]      indis, indis_n;
  logic [4:0]      kaydirma, kaydirma_n;
  logic            eslik, eslik_n;
  logic            seri_n;
  logic            cek, sayac_artir;
  logic            calisiyor;

  logic [4:0]      bellek [FIFO_DERINLIK];
  logic [AW-1:0]   yaz_ptr, oku_ptr;

  logic            yasal, aktarim, itme, gecersiz, bos_degil, son;

  // Handshake and legality of the incoming word
  always_comb begin
    yasal     = filtrelenmis_resim[4] ? (filtrelenmis_resim[3:1] == 3'b000)
                                      : !filtrelenmis_resim[0];
    aktarim   = giris_gecerli && giris_hazir;
    itme      = aktarim && yasal;
    gecersiz  = aktarim && !yasal;
    bos_degil = (doluluk != '0);
    son       = (zaman == SON);
    mesgul    = (durum != BOS);
    // calisiyor keeps ready low while in reset even though the FIFO is empty
    giris_hazir = calisiyor && (doluluk != DOLU);
  end

  // FIFO storage; pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk) begin
    if (itme) bellek[yaz_ptr] <= filtrelenmis_resim;
  end

  // FIFO pointers, occupancy and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yaz_ptr         <= '0;
      oku_ptr         <= '0;
      doluluk         <= '0;
      piksel_sayaci   <= '0;
      gecersiz_sayaci <= '0;
      calisiyor       <= 1'b0;
    end else begin
      calisiyor <= 1'b1;
      if (itme) yaz_ptr <= yaz_ptr + AW'(1);
      if (cek)  oku_ptr <= oku_ptr + AW'(1);
      case ({itme, cek})
        2'b10:   doluluk <= doluluk + (AW+1)'(1);
        2'b01:   doluluk <= doluluk - (AW+1)'(1);
        default: doluluk <= doluluk;
      endcase
      if (sayac_artir) piksel_sayaci <= piksel_sayaci + 8'd1;
      if (gecersiz && (gecersiz_sayaci != 8'hFF))
        gecersiz_sayaci <= gecersiz_sayaci + 8'd1;
    end
  end

  // Transmit FSM state register; serial line registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum      <= BOS;
      zaman      <= '0;
      indis      <= '0;
      kaydirma   <= '0;
      eslik      <= 1'b0;
      seri_cikis <= 1'b1;
    end else begin
      durum      <= durum_n;
      zaman      <= zaman_n;
      indis      <= indis_n;
      kaydirma   <= kaydirma_n;
      eslik      <= eslik_n;
      seri_cikis <= seri_n;
    end
  end

  // Next-state, pop and line-level decode
  always_comb begin
    durum_n     = durum;
    zaman_n     = zaman + TW'(1);
    indis_n     = indis;
    kaydirma_n  = kaydirma;
    eslik_n     = eslik;
    cek         = 1'b0;
    sayac_artir = 1'b0;
    case (durum)
      BOS: begin
        zaman_n = '0;
        if (bos_degil) begin
          cek        = 1'b1;
          kaydirma_n = bellek[oku_ptr];
          eslik_n    = ^bellek[oku_ptr];
          durum_n    = BASLA;
        end
      end
      BASLA: if (son) begin
        zaman_n = '0;
        indis_n = 3'd4;
        durum_n = VERI;
      end
      VERI: if (son) begin
        zaman_n = '0;
        if (indis == 3'd0) durum_n = ESLIK;
        else               indis_n = indis - 3'd1;
      end
      ESLIK: if (son) begin
        zaman_n = '0;
        durum_n = DUR;
      end
      DUR: if (son) begin
        zaman_n     = '0;
        sayac_artir = 1'b1;
        // back-to-back frames: pop straight into the next start bit
        if (bos_degil) begin
          cek        = 1'b1;
          kaydirma_n = bellek[oku_ptr];
          eslik_n    = ^bellek[oku_ptr];
          durum_n    = BASLA;
        end else begin
          durum_n = BOS;
        end
      end
      default: begin
        durum_n = BOS;
        zaman_n = '0;
      end
    endcase

    seri_n = 1'b1;
    case (durum_n)
      BASLA:   seri_n = 1'b0;
      VERI:    seri_n = kaydirma_n[indis_n];
      ESLIK:   seri_n = eslik_n;
      default: seri_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_filtre_serilestirici.sv
// tb_filtre_serilestirici: scoreboard bench; legal words queued at acceptance,
// serial frames captured cycle-by-cycle and compared against a waveform model.
module tb_filtre_serilestirici;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int CW = 8 * B;

  logic       clk, rst_n;
  logic [4:0] filtrelenmis_resim;
  logic       giris_gecerli, giris_hazir, seri_cikis, mesgul;
  logic [$clog2(D):0] doluluk;
  logic [7:0] piksel_sayaci, gecersiz_sayaci;

  filtre_serilestirici #(.FIFO_DERINLIK(D), .BIT_BOLEN(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .filtrelenmis_resim(filtrelenmis_resim),
    .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .seri_cikis(seri_cikis), .mesgul(mesgul), .doluluk(doluluk),
    .piksel_sayaci(piksel_sayaci), .gecersiz_sayaci(gecersiz_sayaci)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned test_say = 0;
  int unsigned hata_say = 0;
  int unsigned kenar = 0;
  int unsigned son_kabul = 0;
  int unsigned cerceve_say = 0;
  logic [4:0]  bek_q[$];
  int unsigned bas_q[$];

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    test_say++;
    if (gozlenen !== beklenen) begin
      hata_say++;
      $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  function automatic bit yasal_mi(input logic [4:0] w);
    if (w[4]) return (w[3:1] == 3'b000);
    return (w[0] == 1'b0);
  endfunction

  // Expected line waveform: start, data MSB-first, even parity, stop
  function automatic logic [CW-1:0] dalga_modeli(input logic [4:0] w);
    logic [7:0]    bitler;
    logic [CW-1:0] r;
    bitler = {1'b0, w, ^w, 1'b1};
    r = '0;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < B; c++)
        r[CW-1-(k*B+c)] = bitler[7-k];
    return r;
  endfunction

  always @(posedge clk) kenar++;

  // Serial monitor: captures each frame and checks it against the queue head
  bit            aktif = 0;
  int            faz = 0;
  logic [CW-1:0] dalga;
  logic [4:0]    mon_kelime;
  always @(negedge clk) begin
    if (!rst_n) begin
      aktif = 0;
    end else if (!aktif) begin
      if (seri_cikis == 1'b0) begin
        aktif = 1;
        faz   = 1;
        dalga = '0;
        dalga[CW-1] = seri_cikis;
        bas_q.push_back(kenar);
        kontrol("kuyruk_dolu", 64'(bek_q.size() != 0), 64'd1);
        mon_kelime = (bek_q.size() != 0) ? bek_q.pop_front() : 5'h1F;
      end
    end else begin
      dalga[CW-1-faz] = seri_cikis;
      faz++;
      if (faz == CW) begin
        aktif = 0;
        cerceve_say++;
        kontrol("cerceve", 64'(dalga), 64'(dalga_modeli(mon_kelime)));
      end
    end
  end

  // Called at a negedge; leaves giris_gecerli high for streaming
  task automatic gonder(input logic [4:0] w);
    int n;
    filtrelenmis_resim = w;
    giris_gecerli      = 1'b1;
    n = 0;
    while (!giris_hazir && n < 200) begin
      @(negedge clk);
      n++;
    end
    kontrol("hazir", 64'(giris_hazir), 64'd1);
    if (giris_hazir && yasal_mi(w)) bek_q.push_back(w);
    @(negedge clk);
    son_kabul = kenar;
  endtask

  task automatic birak();
    giris_gecerli = 1'b0;
  endtask

  task automatic bekle_bos(input int limit);
    int n;
    n = 0;
    while ((mesgul || doluluk != '0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    kontrol("bosalma", 64'(mesgul), 64'd0);
  endtask

  task automatic sifirla();
    @(negedge clk);
    rst_n = 1'b0;
    giris_gecerli = 1'b0;
    bek_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cerceve_say = 0;
    bas_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: gozlenen=timeout beklenen=finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] akis [6];
  logic [4:0] w;
  int unsigned sakli;

  initial begin
    rst_n = 1'b0;
    giris_gecerli = 1'b0;
    filtrelenmis_resim = '0;
    repeat (3) @(negedge clk);
    kontrol("rst_seri", 64'(seri_cikis), 64'd1);
    kontrol("rst_mesgul", 64'(mesgul), 64'd0);
    kontrol("rst_doluluk", 64'(doluluk), 64'd0);
    kontrol("rst_piksel", 64'(piksel_sayaci), 64'd0);
    kontrol("rst_gecersiz", 64'(gecersiz_sayaci), 64'd0);
    kontrol("rst_hazir", 64'(giris_hazir), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single word, latency and completion
    gonder(5'b10001);
    birak();
    bekle_bos(100);
    kontrol("t1_gecikme", 64'((bas_q.size() != 0) ? bas_q[0] - son_kabul : 99), 64'd1);
    kontrol("t1_piksel", 64'(piksel_sayaci), 64'd1);
    kontrol("t1_mesgul", 64'(mesgul), 64'd0);
    kontrol("t1_seri", 64'(seri_cikis), 64'd1);

    // 2: odd-weight word, parity 1
    gonder(5'b01110);
    birak();
    bekle_bos(100);
    kontrol("t2_piksel", 64'(piksel_sayaci), 64'd2);
    kontrol("t2_gecersiz", 64'(gecersiz_sayaci), 64'd0);

    // 3: illegal words are consumed and counted
    gonder(5'b11000);
    gonder(5'b00101);
    birak();
    repeat (40) @(negedge clk);
    kontrol("t3_gecersiz", 64'(gecersiz_sayaci), 64'd2);
    kontrol("t3_doluluk", 64'(doluluk), 64'd0);
    kontrol("t3_seri", 64'(seri_cikis), 64'd1);
    kontrol("t3_mesgul", 64'(mesgul), 64'd0);
    kontrol("t3_piksel", 64'(piksel_sayaci), 64'd2);

    // 4: streaming six words, FIFO fills, back-to-back frames
    sifirla();
    akis = '{5'b00000, 5'b10000, 5'b00010, 5'b10001, 5'b01100, 5'b01110};
    for (int i = 0; i < 5; i++) gonder(akis[i]);
    kontrol("t4_dolu", 64'(doluluk), 64'(D));
    kontrol("t4_hazir_dusuk", 64'(giris_hazir), 64'd0);
    gonder(akis[5]);
    birak();
    bekle_bos(400);
    kontrol("t4_piksel", 64'(piksel_sayaci), 64'd6);
    kontrol("t4_cerceve", 64'(cerceve_say), 64'd6);
    kontrol("t4_bitisik", 64'((bas_q.size() == 6) ? bas_q[5] - bas_q[0] : 0), 64'(5 * CW));

    // 5: reset in the middle of the data bits with two words queued
    sifirla();
    gonder(5'b10000);
    gonder(5'b00100);
    gonder(5'b01000);
    birak();
    repeat (3 * B) @(negedge clk);
    kontrol("t5_mesgul_once", 64'(mesgul), 64'd1);
    kontrol("t5_doluluk_once", 64'(doluluk), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    kontrol("t5_seri", 64'(seri_cikis), 64'd1);
    kontrol("t5_doluluk", 64'(doluluk), 64'd0);
    kontrol("t5_piksel", 64'(piksel_sayaci), 64'd0);
    kontrol("t5_mesgul", 64'(mesgul), 64'd0);
    bek_q.delete();
    sakli = cerceve_say;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bas_q.delete();
    repeat (100) @(negedge clk);
    kontrol("t5_cerceve_yok", 64'(bas_q.size()), 64'd0);
    kontrol("t5_cerceve_say", 64'(cerceve_say), 64'(sakli));
    kontrol("t5_seri_bos", 64'(seri_cikis), 64'd1);

    // 6: frame counter wrap and illegal counter saturation
    sifirla();
    for (int i = 0; i < 256; i++) begin
      do w = 5'($urandom_range(0, 31)); while (!yasal_mi(w));
      gonder(w);
    end
    birak();
    bekle_bos(400);
    kontrol("t6_cerceve", 64'(cerceve_say), 64'd256);
    kontrol("t6_piksel_sarma", 64'(piksel_sayaci), 64'd0);
    for (int i = 0; i < 300; i++) begin
      do w = 5'($urandom_range(0, 31)); while (yasal_mi(w));
      gonder(w);
      if (i == 254) kontrol("t6_gecersiz_255", 64'(gecersiz_sayaci), 64'd255);
    end
    birak();
    repeat (2) @(negedge clk);
    kontrol("t6_gecersiz_doyma", 64'(gecersiz_sayaci), 64'd255);
    kontrol("t6_doluluk", 64'(doluluk), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_say, hata_say);
    $finish;
  end

endmodule

// File: doc/filtre_serilestirici.md
Name: filtre_serilestirici

Overview:
Downstream consumer of the image filter stage. It accepts the filter's 5-bit filtered pixel words through a valid/ready handshake and checks each word against the filter's legal output patterns. Legal words are buffered in a small FIFO. Each buffered word is transmitted MSB-first on a single serial line as a framed word: start bit, data, even parity, stop bit. Illegal words are dropped and counted.

Parameters:
FIFO_DERINLIK, 4, FIFO depth in words; power of two, minimum 2.
BIT_BOLEN, 4, clock cycles per serial bit; minimum 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
filtrelenmis_resim  input  5  filtered pixel word from the filter stage.
giris_gecerli  input  1  input word valid.
giris_hazir  output  1  block can accept a word.
seri_cikis  output  1  serial line; idle high.
mesgul  output  1  a frame is in progress (any state other than BOS).
doluluk  output  clog2(FIFO_DERINLIK)+1  current FIFO occupancy.
piksel_sayaci  output  8  count of completed frames; wraps 255->0.
gecersiz_sayaci  output  8  count of dropped illegal words; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO flushed; FSM in BOS; all counters and the bit timer cleared.
  - Outputs during reset: seri_cikis=1, mesgul=0, doluluk=0, piksel_sayaci=0, gecersiz_sayaci=0, giris_hazir=0.
  - Reset mid-frame aborts the frame immediately; no partial frame resumes after reset.
- After reset: giris_hazir = (doluluk != FIFO_DERINLIK). It is derived from registered state only and does not depend on pop in the same cycle.
- Transfer occurs on an edge where giris_gecerli=1 and giris_hazir=1.
- Legality check on a transferred word w:
  - w[4]=1 is legal only if w[3:1]=000.
  - w[4]=0 is legal only if w[0]=0.
  - A legal word is pushed into the FIFO.
  - An illegal word is consumed (handshake completes) but not stored; gecersiz_sayaci is incremented, saturating at 255.
- FIFO: circular buffer with wrapping read/write pointers.
  - Push and pop on the same edge is allowed when not full; doluluk is unchanged in that case.
  - No push while full; no pop while empty.
- FSM states: BOS, BASLA, VERI, ESLIK, DUR.
  - BOS: seri_cikis=1. If FIFO is non-empty, pop the word into the shift register, compute even parity (XOR of 5 bits), clear the bit timer and go to BASLA.
  - BASLA: seri_cikis=0 for BIT_BOLEN cycles, then go to VERI with the bit index at 4.
  - VERI: seri_cikis = word[bit index], each bit held BIT_BOLEN cycles, sent bit 4 down to bit 0. After bit 0, go to ESLIK.
  - ESLIK: seri_cikis = parity, held BIT_BOLEN cycles.
  - DUR: seri_cikis=1 for BIT_BOLEN cycles. On the last cycle, piksel_sayaci is incremented (wrapping).
  - Exit from DUR: if the FIFO is non-empty, pop and go directly to BASLA with no idle gap; otherwise go to BOS.
- Frame length: exactly 8*BIT_BOLEN cycles.
- Latency: a legal word accepted at edge N into an empty FIFO with the FSM in BOS is popped at edge N+1. seri_cikis goes low after edge N+1.
- seri_cikis is registered and glitch-free.

Test Plan:
1. BIT_BOLEN=4, single word 5'b10001:
   - Expected: seri_cikis sequence 0,1,0,0,0,1,0,1, each held 4 cycles; start bit begins one edge after acceptance.
   - Afterwards: piksel_sayaci=1, mesgul=0, seri_cikis=1.
2. Single word 5'b01110:
   - Expected: sequence 0,0,1,1,1,0,1,1 (parity=1); gecersiz_sayaci stays 0.
3. Illegal words 5'b11000 then 5'b00101:
   - Expected: both handshakes complete; gecersiz_sayaci=2; doluluk stays 0; seri_cikis stays 1; mesgul stays 0.
4. Six legal words with giris_gecerli held high continuously, FIFO_DERINLIK=4:
   - Expected: word 1 is popped immediately and words 2-5 fill the FIFO; giris_hazir deasserts while doluluk=4 and reasserts after the next pop.
   - Frames are sent back-to-back with no gap in order; piksel_sayaci=6 after 192 cycles of transmission.
5. rst_n pulsed low during the VERI state of a frame, with 2 words queued:
   - Expected: seri_cikis=1 immediately; doluluk=0; piksel_sayaci=0; mesgul=0.
   - After release: no further frames transmitted.
6. Wrap and saturation:
   - 256 legal words -> piksel_sayaci returns to 0.
   - 300 illegal words -> gecersiz_sayaci=255.
